// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline control blocks.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int MD_CNT_W   = 4;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hz_busy_counter.sv
// Loadable down-counter with zero flag; holds at 0 rather than wrapping.
module hz_busy_counter
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for load-use, taken branch and multi-cycle mul/div.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_events counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdE,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              MdStartE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events,
`endif
    output hz_state_t         fsm_state
);

    hz_state_t state, next_state;
    logic      lu;
    logic      md_load, md_dec, md_zero;

    assign lu = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // Issue cycle counts as one EX cycle and the zero cycle as another,
    // so the busy counter only covers the remaining MD_LATENCY-2.
    hz_busy_counter u_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_load),
        .load_val (MD_CNT_W'(MD_LATENCY - 2)),
        .dec      (md_dec),
        .zero     (md_zero)
    );

    assign md_dec = (state == MD_BUSY);

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        md_load    = 1'b0;
        next_state = state;
        case (state)
            RUN: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (MdStartE) begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    FlushM     = 1'b1;
                    md_load    = 1'b1;
                    next_state = MD_BUSY;
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MD_BUSY: begin
                // On the zero cycle the result moves on to MEM, so nothing is held.
                if (!md_zero) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign fsm_state = state;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, StallF};
            flush_events <= flush_events + {31'd0, FlushD};
        end
    end
`endif

endmodule
